// File: rtl/display_7seg_mux_bin.sv
// Multiplexed seven-segment driver: binary input converted to BCD by a sequential
// double-dabble engine, then scanned digit by digit onto shared segment lines.
module display_7seg_mux_bin #(
  parameter int unsigned N_DIG      = 4,
  parameter int unsigned W_BIN      = 14,
  parameter int unsigned REFRESH    = 100000,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [W_BIN-1:0] i_bin_in,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_blank_lz,
  output logic             o_busy,
  output logic             o_overflow,
  output logic [6:0]       o_seg,
  output logic [N_DIG-1:0] o_an
);

  localparam int unsigned W_BCD  = 4 * (N_DIG + 1);
  localparam int unsigned W_DISP = 4 * N_DIG;
  localparam int unsigned W_REF  = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int unsigned W_IDX  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned W_CNT  = $clog2(W_BIN + 1);

  localparam logic [6:0]       SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [N_DIG-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e r_state, w_state_d;

  logic [W_BIN-1:0]  r_sh;
  logic [W_BCD-1:0]  r_bcd;
  logic [W_BCD-1:0]  w_adj;
  logic [W_CNT-1:0]  r_cnt;
  logic [W_DISP-1:0] r_disp;
  logic              r_ovf;
  logic              r_busy;
  logic              w_busy_d;
  logic              w_start;
  logic              w_shift;
  logic              w_commit;

  logic [W_REF-1:0]  r_ref;
  logic [W_IDX-1:0]  r_idx;
  logic [6:0]        r_seg;
  logic [N_DIG-1:0]  r_an;

  logic [3:0]        w_nib;
  logic              w_hi_zero;
  logic [6:0]        w_pat;
  logic [6:0]        w_seg_d;
  logic [N_DIG-1:0]  w_an_oh;
  logic [N_DIG-1:0]  w_an_d;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (i_load) w_state_d = StConv;
      StConv: if (r_cnt == W_CNT'(W_BIN - 1)) w_state_d = StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // busy registered from the next state so it tracks (state != IDLE) exactly
  always_comb begin
    w_start  = (r_state == StIdle) && i_load;
    w_shift  = (r_state == StConv);
    w_commit = (r_state == StDone);
    w_busy_d = (w_state_d != StIdle);
  end

  always_comb begin
    w_adj = r_bcd;
    for (int n = 0; n <= int'(N_DIG); n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh   <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_disp <= '0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= w_busy_d;
      if (w_start) begin
        r_sh  <= i_bin_in;
        r_bcd <= '0;
        r_cnt <= '0;
      end
      if (w_shift) begin
        r_bcd <= {w_adj[W_BCD-2:0], r_sh[W_BIN-1]};
        r_sh  <= r_sh << 1;
        r_cnt <= r_cnt + W_CNT'(1);
      end
      if (w_commit) begin
        r_disp <= r_bcd[W_DISP-1:0];
        r_ovf  <= |r_bcd[W_BCD-1:W_DISP];
      end
    end
  end

  // ---------------- scan ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref <= '0;
      r_idx <= '0;
    end else if (i_en) begin
      if (r_ref == W_REF'(REFRESH - 1)) begin
        r_ref <= '0;
        r_idx <= (r_idx == W_IDX'(N_DIG - 1)) ? '0 : r_idx + W_IDX'(1);
      end else begin
        r_ref <= r_ref + W_REF'(1);
      end
    end
  end

  // ---------------- output stage ----------------
  always_comb begin
    w_nib     = r_disp[4*r_idx +: 4];
    w_hi_zero = 1'b1;
    for (int j = 0; j < int'(N_DIG); j++) begin
      if (j >= int'(r_idx) && r_disp[4*j +: 4] != 4'd0) w_hi_zero = 1'b0;
    end

    case (w_nib)
      4'd0: w_pat = 7'b0000001;
      4'd1: w_pat = 7'b1001111;
      4'd2: w_pat = 7'b0010010;
      4'd3: w_pat = 7'b0000110;
      4'd4: w_pat = 7'b1001100;
      4'd5: w_pat = 7'b0100100;
      4'd6: w_pat = 7'b0100000;
      4'd7: w_pat = 7'b0001111;
      4'd8: w_pat = 7'b0000000;
      4'd9: w_pat = 7'b0000100;
      default: w_pat = 7'b1111111;
    endcase
    if (r_ovf) w_pat = 7'b1111110;
    else if (i_blank_lz && r_idx != '0 && w_hi_zero) w_pat = 7'b1111111;

    w_an_oh = N_DIG'(1) << r_idx;
    if (!i_en) begin
      w_an_d  = AN_OFF;
      w_seg_d = SEG_OFF;
    end else begin
      w_an_d  = (ACTIVE_LOW != 0) ? ~w_an_oh : w_an_oh;
      w_seg_d = (ACTIVE_LOW != 0) ? w_pat : ~w_pat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg_d;
      r_an  <= w_an_d;
    end
  end

  assign o_busy     = r_busy;
  assign o_overflow = r_ovf;
  assign o_seg      = r_seg;
  assign o_an       = r_an;

endmodule

// File: tb/tb_display_7seg_mux_bin.sv
// Directed bench for display_7seg_mux_bin with a fast refresh (4 cycles per digit).
module tb_display_7seg_mux_bin;

  logic        clk;
  logic        rst;
  logic [13:0] bin_in;
  logic        load;
  logic        en;
  logic        blank_lz;
  logic        busy;
  logic        overflow;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks;
  int failures;

  display_7seg_mux_bin #(
    .N_DIG     (4),
    .W_BIN     (14),
    .REFRESH   (4),
    .ACTIVE_LOW(1)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_bin_in  (bin_in),
    .i_load    (load),
    .i_en      (en),
    .i_blank_lz(blank_lz),
    .o_busy    (busy),
    .o_overflow(overflow),
    .o_seg     (seg),
    .o_an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0]     bin;
    logic            blz;
    logic            ovf;
    logic [3:0][6:0] seg;  // seg[k] = expected pattern for digit k
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] v, input string name);
    int n;
    n = 0;
    while (an !== v && n < 64) begin
      step();
      n++;
    end
    if (an !== v) chk(name, 32'(an), 32'(v));
  endtask

  // Load a value and measure how many sampled cycles busy stays high.
  task automatic do_load(input logic [13:0] v, input string name);
    int n;
    bin_in = v;
    load   = 1'b1;
    step();
    load   = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk({name, "_busy_len"}, n, 15);
  endtask

  // Align to the first cycle of digit 0, then walk one full scan period.
  task automatic check_scan(input logic [3:0][6:0] exp_seg, input string name);
    logic [3:0] exp_an;
    wait_an(4'b0111, {name, "_sync3"});
    wait_an(4'b1110, {name, "_sync0"});
    for (int k = 0; k < 4; k++) begin
      exp_an = ~(4'b0001 << k);
      chk($sformatf("%s_an%0d", name, k), 32'(an), 32'(exp_an));
      chk($sformatf("%s_seg%0d", name, k), 32'(seg), 32'(exp_seg[k]));
      repeat (3) step();
      chk($sformatf("%s_an%0d_hold", name, k), 32'(an), 32'(exp_an));
      step();
    end
    chk({name, "_wrap"}, 32'(an), 32'(4'b1110));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bin_in   = '0;
    load     = 1'b0;
    en       = 1'b1;
    blank_lz = 1'b0;

    vecs[0] = '{bin: 14'd1234, blz: 1'b0, ovf: 1'b0,
                seg: {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    vecs[1] = '{bin: 14'd305, blz: 1'b1, ovf: 1'b0,
                seg: {7'b1111111, 7'b0000110, 7'b0000001, 7'b0100100}};
    vecs[2] = '{bin: 14'd7, blz: 1'b1, ovf: 1'b0,
                seg: {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}};
    vecs[3] = '{bin: 14'd0, blz: 1'b1, ovf: 1'b0,
                seg: {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
    vecs[4] = '{bin: 14'd12000, blz: 1'b1, ovf: 1'b1,
                seg: {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
    vecs[5] = '{bin: 14'd9999, blz: 1'b1, ovf: 1'b0,
                seg: {7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100}};

    #3;
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_ovf", 32'(overflow), 32'(1'b0));
    chk("rst_an", 32'(an), 32'(4'b1111));
    chk("rst_seg", 32'(seg), 32'(7'b1111111));
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      blank_lz = vecs[i].blz;
      do_load(vecs[i].bin, $sformatf("v%0d", i));
      step();
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      check_scan(vecs[i].seg, $sformatf("v%0d", i));
    end

    // load pulsed during busy is dropped; 1234 must remain on display
    blank_lz = 1'b0;
    bin_in   = 14'd1234;
    load     = 1'b1;
    step();
    load = 1'b0;
    repeat (4) step();
    chk("ign_busy_c5", 32'(busy), 32'(1'b1));
    bin_in = 14'd9999;
    load   = 1'b1;
    step();
    load = 1'b0;
    wait (busy === 1'b0 || $time > 5000000);
    repeat (20) step();
    chk("ign_busy_idle", 32'(busy), 32'(1'b0));
    check_scan(vecs[0].seg, "ign");

    // display enable: blank for 10 cycles then resume on the same digit
    wait_an(4'b0111, "en_sync3");
    wait_an(4'b1110, "en_sync0");
    repeat (4) step();
    chk("en_pre_an", 32'(an), 32'(4'b1101));
    en = 1'b0;
    step();
    chk("en_off_an", 32'(an), 32'(4'b1111));
    chk("en_off_seg", 32'(seg), 32'(7'b1111111));
    repeat (9) step();
    chk("en_off_an_late", 32'(an), 32'(4'b1111));
    en = 1'b1;
    step();
    chk("en_resume_an", 32'(an), 32'(4'b1101));
    chk("en_resume_seg", 32'(seg), 32'(7'b0000110));

    // asynchronous reset in the middle of a conversion, with overflow previously set
    blank_lz = 1'b1;
    do_load(14'd12000, "ovf2");
    step();
    chk("ovf2_ovf", 32'(overflow), 32'(1'b1));
    bin_in = 14'd9999;
    load   = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    chk("mid_busy", 32'(busy), 32'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'(1'b0));
    chk("arst_ovf", 32'(overflow), 32'(1'b0));
    chk("arst_an", 32'(an), 32'(4'b1111));
    chk("arst_seg", 32'(seg), 32'(7'b1111111));
    step();
    rst = 1'b0;
    step();
    chk("post_rst_an", 32'(an), 32'(4'b1110));
    chk("post_rst_seg", 32'(seg), 32'(7'b0000001));
    chk("post_rst_busy", 32'(busy), 32'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
